// File: rtl/console_uart_tx.sv
// Memory-mapped console: byte writes to DATA are queued in a FIFO and sent as UART 8N1 on txd.
// Ack is registered, one cycle after accept; DATA writes stall (no ack) while the FIFO is full.
module console_uart_tx #(
  parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
  parameter int unsigned CLK_DIV      = 868,
  parameter int unsigned DEPTH        = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        txd
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FIFO_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Bus-side registers
  logic          ready_q, ready_d;
  logic [31:0]   rdata_q, rdata_d;

  // FIFO
  logic [7:0]    fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Transmitter
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  logic          sel, is_wr, is_data, accept, push, pop;
  logic          fifo_full, fifo_empty, tx_busy, bit_end;
  logic [7:0]    fifo_head;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{mem_wdata[31:8], mem_addr[1:0]};

  assign fifo_full  = (count_q == FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign fifo_head  = fifo_mem[rd_ptr_q];
  assign tx_busy    = (state_q != S_IDLE);

  assign sel     = mem_valid && (mem_addr[31:3] == CONSOLE_ADDR[31:3]);
  assign is_wr   = |mem_wstrb;
  assign is_data = !mem_addr[2];
  // Fullness uses the registered count, so a pop in the same cycle never admits a push.
  assign accept  = sel && !ready_q && (!is_wr || !is_data || !fifo_full);
  assign push    = accept && is_wr && is_data && mem_wstrb[0];

  assign status = {16'h0000, 8'(count_q), 5'b00000, fifo_empty, fifo_full, tx_busy};

  always_comb begin
    ready_d = accept;
    rdata_d = '0;
    if (accept && !is_wr && !is_data) begin
      rdata_d = status;
    end
  end

  assign bit_end = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          div_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          div_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          div_d   = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          div_d = '0;
          // Chain straight into the next start bit when more bytes are waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign txd       = txd_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Bench for console_uart_tx: directed bus scenarios plus a frame-timeline model checked every cycle.
module tb_console_uart_tx;

  localparam int DIV = 4;
  localparam int DEP = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        txd;

  int n_checks = 0;
  int n_fail = 0;

  console_uart_tx #(
    .CONSOLE_ADDR(BASE),
    .CLK_DIV(DIV),
    .DEPTH(DEP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .mem_valid(mem_valid),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: queue of waiting bytes plus the position inside the frame on the wire.
  logic [7:0] mq[$];
  int         pos = -1;
  logic [7:0] cur = '0;
  logic       exp_ready = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic       exp_txd = 1'b1;
  bit         model_on = 1'b0;
  int         m_sz, m_bit;
  bit         m_sel, m_wr, m_dat, m_acc, m_busy;

  always @(posedge clk) begin
    if (!resetn) begin
      mq.delete();
      pos = -1;
      exp_ready = 1'b0;
      exp_rdata = '0;
      exp_txd = 1'b1;
      model_on = 1'b1;
    end else begin
      m_sz   = mq.size();
      m_busy = (pos >= 0);
      m_sel  = mem_valid && ((mem_addr >> 3) == (BASE >> 3));
      m_wr   = (mem_wstrb != 4'h0);
      m_dat  = (mem_addr[2] == 1'b0);
      m_acc  = m_sel && !exp_ready && (!m_wr || !m_dat || (m_sz < DEP));
      exp_rdata = (m_acc && !m_wr && !m_dat) ?
                  {16'h0, 8'(m_sz), 5'h0, (m_sz == 0), (m_sz == DEP), m_busy} : 32'h0;
      exp_ready = m_acc;
      if (pos < 0) begin
        if (m_sz > 0) begin cur = mq.pop_front(); pos = 0; end
      end else if (pos == 10*DIV - 1) begin
        if (m_sz > 0) begin cur = mq.pop_front(); pos = 0; end
        else pos = -1;
      end else begin
        pos++;
      end
      if (m_acc && m_wr && m_dat && mem_wstrb[0]) mq.push_back(mem_wdata[7:0]);
      if (pos < 0) exp_txd = 1'b1;
      else begin
        m_bit = pos / DIV;
        if (m_bit == 0) exp_txd = 1'b0;
        else if (m_bit == 9) exp_txd = 1'b1;
        else exp_txd = cur[m_bit-1];
      end
    end
  end

  logic prev_ready = 1'b0;
  always @(negedge clk) begin
    if (model_on) begin
      chk("mem_ready", mem_ready, exp_ready);
      chk("mem_rdata", mem_rdata, exp_rdata);
      chk("txd", txd, exp_txd);
      chk("ready_two_cycles", prev_ready && mem_ready, 0);
      prev_ready = mem_ready;
    end
  end

  // Call at a negedge; returns at the negedge where the ack was seen (or budget ran out).
  task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input int budget, output logic [31:0] rd, output int waits,
                        output bit acked);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
    acked = 1'b0; waits = 0; rd = '0;
    while (!acked && waits < budget) begin
      @(negedge clk);
      waits++;
      if (mem_ready) begin acked = 1'b1; rd = mem_rdata; end
    end
    mem_valid = 1'b0;
  endtask

  task automatic acc_chk(input string nm, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, input bit exp_ack,
                         output logic [31:0] rd, output int waits);
    bit ak;
    access(a, wd, ws, exp_ack ? 200 : 8, rd, waits, ak);
    chk(nm, ak, exp_ack);
  endtask

  initial begin
    logic [31:0] rd;
    int w;
    int waits[6];
    logic [39:0] pat;
    int zeros;

    repeat (3) @(negedge clk);
    chk("reset_ready", mem_ready, 0);
    chk("reset_rdata", mem_rdata, 0);
    chk("reset_txd", txd, 1);
    resetn = 1'b1;
    @(negedge clk);

    // Single byte 0x55: exact waveform
    acc_chk("wr55_ack", BASE, 32'h55, 4'hF, 1, rd, w);
    chk("wr55_latency", w, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pat[39-i] = txd;
    end
    chk("frame55", pat, 40'h0F0F0F0F0F);
    repeat (2) @(negedge clk);
    acc_chk("st_idle_ack", BASE + 4, 0, 4'h0, 1, rd, w);
    chk("st_idle", rd, 32'h0000_0004);

    // Back-to-back 0x01..0x06: sixth stalls until byte 2 leaves the FIFO
    @(negedge clk);
    for (int k = 0; k < 6; k++) acc_chk("b2b_ack", BASE, 32'(k + 1), 4'h1, 1, rd, waits[k]);
    chk("b2b_wait1", waits[0], 1);
    for (int k = 1; k < 5; k++) chk("b2b_wait_nostall", waits[k], 2);
    chk("b2b_wait6_stall", waits[5], 34);
    acc_chk("st_full_ack", BASE + 4, 0, 4'h0, 1, rd, w);
    chk("st_full_busy", rd, 32'h0000_0403);
    repeat (6*10*DIV + 20) @(negedge clk);

    // Two bytes queued behind an in-flight frame
    acc_chk("q_ack", BASE, 32'hA5, 4'h1, 1, rd, w);
    acc_chk("q_ack", BASE, 32'h3C, 4'h1, 1, rd, w);
    acc_chk("q_ack", BASE, 32'h81, 4'h1, 1, rd, w);
    acc_chk("st_q2_ack", BASE + 4, 0, 4'h0, 1, rd, w);
    chk("st_q2", rd, 32'h0000_0201);

    // Reset in the middle of the data bits with three queued
    acc_chk("q_ack", BASE, 32'h7E, 4'h1, 1, rd, w);
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    chk("midreset_txd", txd, 1);
    chk("midreset_ready", mem_ready, 0);
    resetn = 1'b1;
    @(negedge clk);
    acc_chk("st_post_reset_ack", BASE + 4, 0, 4'h0, 1, rd, w);
    chk("st_post_reset", rd, 32'h0000_0004);
    zeros = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txd == 1'b0) zeros++;
    end
    chk("no_frames_after_reset", zeros, 0);

    // Address decode and byte-lane strobe
    acc_chk("unsel_plus8", BASE + 8, 32'h11, 4'hF, 0, rd, w);
    acc_chk("unsel_below", 32'h0FFF_FFFC, 32'h22, 4'hF, 0, rd, w);
    acc_chk("wstrb_lane1_ack", BASE, 32'h0000_2200, 4'b0010, 1, rd, w);
    zeros = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txd == 1'b0) zeros++;
    end
    chk("wstrb_lane1_no_frame", zeros, 0);
    acc_chk("st_after_lane1_ack", BASE + 4, 0, 4'h0, 1, rd, w);
    chk("st_after_lane1", rd, 32'h0000_0004);

    // Random traffic, checked cycle by cycle against the model
    for (int i = 0; i < 80; i++) begin
      int r;
      logic [31:0] a;
      bit exp_ack;
      r = $urandom_range(0, 5);
      exp_ack = 1'b1;
      case (r)
        0, 1, 2: a = BASE;
        3, 4:    a = BASE + 4;
        default: begin
          a = ($urandom_range(0, 1) == 0) ? BASE + 8 : BASE - 8;
          exp_ack = 1'b0;
        end
      endcase
      acc_chk("rnd_ack", a, $urandom, (r == 3) ? 4'h0 : 4'($urandom_range(0, 15)), exp_ack, rd, w);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    repeat ((DEP + 1)*10*DIV + 20) @(negedge clk);
    chk("drained_model", mq.size(), 0);
    chk("drained_txd", txd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
